// File: rtl/rr_ring_arbiter_pkg.sv
// Shared types and helpers for the round-robin ring arbiter.
package rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Widest requester vector the helpers below can handle.
    localparam int MAX_N = 32;

    // Circular left rotate of the low n bits of v by one position.
    function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) r[(i + 1) % n] = v[i];
        end
        return r;
    endfunction

    // Binary index of the set bit of a one-hot (or zero) vector.
    function automatic logic [4:0] onehot2bin(input logic [MAX_N-1:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (v[i]) r = r | i[4:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_ring_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Handshake: req is a level; the owner keeps req high to keep the grant and
// drops it to release. grant/grant_id/busy/timeout are registered.
interface rr_ring_arbiter_if #(parameter int N = 4);
    import rr_arb_pkg::*;

    localparam int ID_W = $clog2(N);

    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic [ID_W-1:0] grant_id;
    logic            busy;
    logic            timeout;
    arb_state_t      state;     // debug view of the arbiter FSM

    modport master (output req, input grant, grant_id, busy, timeout, state);
    modport slave  (input req, output grant, grant_id, busy, timeout, state);

endinterface

// File: rtl/rr_ring_arbiter_pick.sv
// Combinational round-robin picker: first set req bit scanning circularly
// upward from the one-hot pointer, pointer position included.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] ptr_i,
    output logic [N-1:0] win_o,
    output logic         valid_o
);

    logic [N-1:0]   mask;
    logic [N-1:0]   hi_req;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] first;

    // Lower half holds requests at/above ptr, upper half the full vector, so
    // the lowest set bit of the concatenation is the circular winner.
    always_comb begin
        mask    = ~(ptr_i - 1'b1);
        hi_req  = req_i & mask;
        dbl     = {req_i, hi_req};
        first   = dbl & (~dbl + 1'b1);
        win_o   = first[N-1:0] | first[2*N-1:N];
        valid_o = |req_i;
    end

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with one-hot ring pointer and optional hold-time limit.
// Each ownership is followed by one idle cycle before re-arbitration.
module rr_ring_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_ring_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(N);
    localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    arb_state_t      state_q, state_d;
    logic [N-1:0]    ptr_q, ptr_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            busy_q, busy_d;
    logic            tmo_q, tmo_d;
    logic [HC_W-1:0] hold_q, hold_d;

    logic [N-1:0]     win;
    logic             win_valid;
    logic             owner_req;
    logic             hold_hit;
    logic [MAX_N-1:0] win_ext;
    logic [MAX_N-1:0] grant_ext;
    logic [MAX_N-1:0] rot_ext;
    logic [4:0]       win_idx;

    rr_pick #(.N(N)) u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .win_o   (win),
        .valid_o (win_valid)
    );

    // A limit of zero means the owner may hold forever.
    assign hold_hit  = (MAX_HOLD != 0) && (hold_q == HC_W'(MAX_HOLD));
    assign owner_req = |(bus.req & grant_q);

    // Next-state logic: grant on IDLE, hold or release (drop/limit) on BUSY.
    always_comb begin
        win_ext            = '0;
        win_ext[N-1:0]     = win;
        grant_ext          = '0;
        grant_ext[N-1:0]   = grant_q;
        rot_ext            = rotl1(grant_ext, N);
        win_idx            = onehot2bin(win_ext);

        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        id_d    = id_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
        tmo_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    grant_d = win;
                    id_d    = win_idx[ID_W-1:0];
                    busy_d  = 1'b1;
                    hold_d  = HC_W'(1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!owner_req || hold_hit) begin
                    // Released owner drops to lowest priority.
                    grant_d = '0;
                    id_d    = '0;
                    busy_d  = 1'b0;
                    hold_d  = '0;
                    ptr_d   = rot_ext[N-1:0];
                    state_d = IDLE;
                    tmo_d   = owner_req;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= {{(N-1){1'b0}}, 1'b1};
            grant_q <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = id_q;
    assign bus.busy     = busy_q;
    assign bus.timeout  = tmo_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Bench for rr_ring_arbiter: two instances (MAX_HOLD=8 and MAX_HOLD=0),
// table-driven vectors, hand sequences for async reset, and a random phase
// checked against a behavioural model through an expected queue.
module tb_rr_ring_arbiter;
    import rr_arb_pkg::*;

    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_ring_arbiter_if #(.N(N)) bus_a ();
    rr_ring_arbiter_if #(.N(N)) bus_b ();

    rr_ring_arbiter #(.N(N), .MAX_HOLD(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    rr_ring_arbiter #(.N(N), .MAX_HOLD(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    // ---------------- vectors and scoreboard ----------------
    typedef struct {
        bit         b;      // 0 = MAX_HOLD 8 instance, 1 = MAX_HOLD 0 instance
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] id;
        logic       busy;
        logic       tmo;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;

    // behavioural model state (pointer kept as an index)
    int m_pidx;
    int m_id;
    int m_hold;
    bit m_busy;

    function automatic void add(input bit b, input logic [3:0] r, input logic [3:0] g,
                                input logic [1:0] id, input logic bs, input logic t,
                                input int reps);
        vec_t v;
        v.b = b; v.req = r; v.grant = g; v.id = id; v.busy = bs; v.tmo = t;
        for (int i = 0; i < reps; i++) vecs.push_back(v);
    endfunction

    task automatic sample(input bit b, input string name);
        logic [7:0] act;
        logic [7:0] exp;
        act = b ? {bus_b.grant, bus_b.grant_id, bus_b.busy, bus_b.timeout}
                : {bus_a.grant, bus_a.grant_id, bus_a.busy, bus_a.timeout};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: expected queue empty, got grant=%b", name, act[7:4]);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL %s @%0t: got grant=%b id=%0d busy=%b timeout=%b, want grant=%b id=%0d busy=%b timeout=%b",
                         name, $time, act[7:4], act[3:2], act[1], act[0],
                         exp[7:4], exp[3:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        if (v.b) begin
            bus_b.req = v.req;
            bus_a.req = '0;
        end else begin
            bus_a.req = v.req;
            bus_b.req = '0;
        end
        exp_q.push_back({v.grant, v.id, v.busy, v.tmo});
        @(posedge clk);
        #1;
        sample(v.b, name);
    endtask

    task automatic run_table(input string name);
        foreach (vecs[i]) apply(vecs[i], name);
        vecs.delete();
    endtask

    function automatic logic [7:0] model_step(input logic [3:0] r);
        logic       t;
        logic [3:0] g;
        logic [1:0] id;
        t = 1'b0;
        if (m_busy) begin
            if (!r[m_id] || m_hold == 8) begin
                t      = r[m_id];
                m_busy = 1'b0;
                m_pidx = (m_id + 1) % 4;
                m_hold = 0;
            end else begin
                m_hold++;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!m_busy && r[(m_pidx + k) % 4]) begin
                    m_busy = 1'b1;
                    m_id   = (m_pidx + k) % 4;
                    m_hold = 1;
                end
            end
        end
        g  = m_busy ? (4'b0001 << m_id) : 4'b0000;
        id = m_busy ? m_id[1:0] : 2'b00;
        return {g, id, m_busy, t};
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: run did not complete within time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [3:0] g;
        logic [1:0] id;
        logic [3:0] r;

        // Reset held with all requests high.
        rst_n     = 1'b0;
        bus_a.req = 4'b1111;
        bus_b.req = 4'b1111;
        #2;
        exp_q.push_back(8'h00); sample(0, "reset_a");
        exp_q.push_back(8'h00); sample(1, "reset_b");
        #10;
        rst_n     = 1'b1;

        add(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 20);
        run_table("idle_after_reset");

        // Single requester, then rotation fairness with a forced release.
        add(0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 3);
        add(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1);   // ptr -> 1000
        add(0, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0, 8);   // owner 3 for MAX_HOLD cycles
        add(0, 4'b1010, 4'b0000, 2'd0, 1'b0, 1'b1, 1);   // forced release, ptr -> 0001
        add(0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0, 1);
        add(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1);   // ptr -> 0100
        add(0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, 1);   // scan wraps 2,3 -> 0
        add(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1);   // ptr -> 0010
        add(0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 4);   // hold count reaches 4
        run_table("single_and_rotation");

        // Asynchronous reset between edges while owner 1 holds.
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(8'h00); sample(0, "async_reset_mid_grant_a");
        exp_q.push_back(8'h00); sample(1, "async_reset_mid_grant_b");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Saturation: every requester in turn, 8 cycles each, timeout idle between.
        g  = 4'b0001;
        id = 2'd0;
        for (int o = 0; o < 5; o++) begin
            add(0, 4'b1111, g, id, 1'b1, 1'b0, 8);
            add(0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1, 1);
            g  = {g[2:0], g[3]};
            id = id + 2'd1;
        end
        add(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1);
        run_table("saturation");

        // Unlimited hold instance.
        add(1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, 50);
        add(1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1);   // ptr -> 0010
        add(1, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0, 1);
        add(1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1);
        run_table("no_hold_limit");

        // Random traffic on the limited instance against the model.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_pidx = 0;
        m_id   = 0;
        m_hold = 0;
        m_busy = 1'b0;
        r      = 4'b0000;
        bus_b.req = '0;
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            exp_q.push_back(model_step(r));
            bus_a.req = r;
            @(posedge clk);
            #1;
            sample(0, "random_model");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_ring_arbiter.md
Name: rr_ring_arbiter

Overview:
Round-robin arbiter that shares one downstream resource among N requesters. Priority rotates via a one-hot ring pointer, the same structure as the team's ring counter. An owner keeps the grant until it drops its request or a hold-time limit forces release. The arbiter sits in front of any shared datapath slot and drives its select and enable.

Parameters:
N, 4, number of requesters (N >= 2)
MAX_HOLD, 8, maximum consecutive grant cycles per ownership; 0 disables the limit
ID_W, $clog2(N), width of grant_id (localparam, not overridable)

Ports:
clk      input   1     rising-edge clock
rst_n    input   1     asynchronous active-low reset
req      input   N     request vector, level-sensitive, one bit per requester
grant    output  N     one-hot grant (all-zero when idle), registered
grant_id output  ID_W  binary index of the set grant bit; 0 when idle, registered
busy     output  1     1 while any grant bit is set, registered
timeout  output  1     1-cycle pulse when an owner is force-released by MAX_HOLD

Behaviour:
- Reset (async, rst_n=0), all taking effect immediately without a clock edge:
  - grant=0, grant_id=0, busy=0, timeout=0
  - ptr=one-hot 1 (bit0), hold_cnt=0, state=IDLE
- Internal state:
  - ptr: N-bit one-hot priority pointer. It is never zero and has exactly one bit set.
  - hold_cnt: counter, width $clog2(MAX_HOLD+1), minimum 1 bit.
  - state: IDLE / BUSY.
- Winner selection (combinational): the first set bit of req found scanning circularly upward from the ptr position, ptr position included.
- IDLE:
  - If req != 0 at a rising edge: grant <= winner, grant_id <= its index, busy <= 1, hold_cnt <= 1, state <= BUSY.
  - Latency from req sampled to grant visible is one clock.
  - If req == 0: stay in IDLE with outputs at 0.
- BUSY, evaluated each edge in this priority order:
  1. req[owner]==0: grant <= 0, busy <= 0, grant_id <= 0, ptr <= rotate-left(grant) (circular), hold_cnt <= 0, state <= IDLE.
  2. MAX_HOLD!=0 and hold_cnt==MAX_HOLD: same as (1), plus timeout <= 1 for exactly one cycle.
  3. Otherwise: hold_cnt <= hold_cnt+1 and the grant is held.
- Grant is asserted for at most MAX_HOLD cycles per ownership.
- Every ownership ends with exactly one idle cycle (grant=0) before re-arbitration. There are no back-to-back grants.
- A released or timed-out owner drops to lowest priority. If it still requests, it wins again only when no other bit of req is set.
- Changes to non-owner req bits during BUSY have no effect until the next IDLE cycle.
- timeout is 0 in every cycle except the one following a forced release.
- grant is always one-hot or zero. grant_id is always consistent with grant.

Decomposition:
- Package rr_arb_pkg:
  - state encoding (IDLE=0, BUSY=1)
  - function rotl1(one-hot, N) for circular left rotate
  - function onehot2bin
- Sub-module rr_pick: purely combinational masked priority picker.
  - Inputs: req, ptr. Outputs: one-hot winner, valid.
  - Implemented as a double-width masked scan.
- Top level holds the FSM, ptr, hold_cnt and output registers.

Test Plan:
1. Reset: rst_n=0 for 12 time units with req=1111, then rst_n=1 and req=0000 for 20 cycles -> grant=0000, busy=0, timeout=0 throughout. Asserting rst_n=0 mid-cycle shows grant=0000 before the next edge.
2. Single requester: req=0100 for 3 cycles, then 0000 -> grant=0100, grant_id=2 one edge after req rises. Grant stays for 3 cycles and clears on the edge after req falls. A following req=0001 is granted (ptr now 1000, scan wraps 3 -> 0).
3. Saturation with MAX_HOLD=8: req=1111 held constant -> grants 0001, 0010, 0100, 1000, 0001, each held 8 cycles. Each is followed by one cycle of grant=0000 with timeout=1.
4. Rotation fairness: after owner 2 releases (ptr=1000), apply req=1010 -> grant=1000 (id 3) first. After its release, grant=0010 (id 1).
5. Async reset mid-grant: during grant=0010 with hold_cnt=4, drop rst_n between edges -> grant=0000, busy=0 immediately. After release, with req=1111, the first grant is 0001.
6. MAX_HOLD=0 instance: req=0001 held 50 cycles -> grant=0001 continuously for 50 cycles and timeout never asserts. It clears one edge after req drops.
